cfg_bus_arbiter: RTL and testbench
==================================

// Module: cfg_bus_arbiter
// PURPOSE
//  Shares the single configuration bus (c_addr/c_valid/c_data/c_ready) between NUM_REQ requesters,
//  e.g. the boot-default sequencer and the host command decoder. One transaction is outstanding at
//  a time. The block waits for the slave's c_ready and returns ack or timeout-error to the requester.
//  Sits between the requesters and the UART/VGA configuration slaves (c_addr 01 = UART, 10 = VGA).
// PARAMETERS
//  NUM_REQ   2   number of requesters (>=2)
//  ADDR_W    2   config address width (WIDTH_CONFIG_ADDR)
//  DATA_W    8   config data width (WIDTH_CONFIG_DATA)
//  TIMEOUT   15  WAIT cycles without c_ready before an error completion (>=1)
// PORTS
//  clk        in   1                clock, rising edge
//  rst        in   1                reset, asynchronous, active-low
//  req_valid  in   NUM_REQ          request pending; held high until own req_ack
//  req_addr   in   NUM_REQ*ADDR_W   per-requester address; slice i = [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W   per-requester data; slice i = [i*DATA_W +: DATA_W]
//  req_ack    out  NUM_REQ          one-cycle completion pulse to the granted requester
//  req_err    out  NUM_REQ          pulses together with req_ack when the transaction timed out
//  c_addr     out  ADDR_W           config bus address (latched copy)
//  c_data     out  DATA_W           config bus data (latched copy)
//  c_valid    out  1                config bus valid
//  c_ready    in   1                slave accept; registered in the slave, 1 cycle after valid
//  busy       out  1                1 whenever the FSM is not IDLE
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE. All outputs are registered and reset to 0 (req_ack, req_err,
//   c_valid, c_addr, c_data, busy). RR pointer=0, timeout counter=0. A reset mid-transaction
//   drops it silently: no ack, and the requester re-requests.
//  FSM:
//   IDLE : if any req_valid, pick winner g (see arbitration), latch addr/data slices -> ISSUE.
//   ISSUE: c_valid=1; c_ready ignored (slave still holds its previous/reset value) -> WAIT, cnt=0.
//   WAIT : c_valid stays 1, addr/data stable. c_ready=1 -> DONE(ok).
//          Else cnt==TIMEOUT-1 -> DONE(err). Else cnt++.
//   DONE : c_valid=0; req_ack[g]=1 and req_err[g]=err for exactly this cycle.
//          ptr = (g+1) mod NUM_REQ -> IDLE.
//  Arbitration: round-robin. Search starts at ptr and wraps NUM_REQ-1 -> 0. Lowest index from ptr wins.
//  Latency: req_valid seen in IDLE at cycle n -> c_valid n+1..n+2 -> req_ack n+3 (best case).
//   Back-to-back transactions from different requesters are 4 cycles apart.
//  req_valid changes during ISSUE/WAIT/DONE are ignored. The latched values are used.
//   req_valid of g must fall on the ack cycle; IDLE samples it one cycle later.
//  Ungranted requesters are not starved: at most NUM_REQ-1 transactions precede them.
//  Slave rejection (c_ready stays 0, e.g. unknown opcode) is reported as a timeout err.
//  Counter width = $clog2(TIMEOUT+1); no wrap possible.
// CONFIGURATION
//  CFG_ARB_FIXED_PRIO_EN defined : fixed priority, index 0 highest. ptr is not used and not updated.
//  CFG_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1 single req0 {addr=01,data=8'h24}, slave acks -> c_valid cycles n+1..n+2,
//    req_ack[0] at n+3, req_err=0.
//  2 req0 and req1 both held from reset -> grants 0,1,0,1 (RR). With the macro defined: 0,0,0.
//  3 slave never raises c_ready, TIMEOUT=15 -> c_valid high 16 cycles,
//    then req_ack[g]=req_err[g]=1 for 1 cycle.
//  4 req1 {addr=10,data=8'h40}: c_addr/c_data stay 10/40 during WAIT even if req_data[1] changes.
//  5 rst pulled low in WAIT -> c_valid=0, busy=0 immediately. No ack. Next grant goes to req0.
//  6 slave holds c_ready=1 from its reset value, req0 issued -> ready ignored in ISSUE.
//    Ack comes only from the c_ready sampled in WAIT.

Source files
------------

// File: rtl/cfg_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single config bus with one transaction outstanding.
// Build option: define CFG_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module cfg_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [ADDR_W-1:0]         c_addr,
    output logic [DATA_W-1:0]         c_data,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] pick;
    logic             pick_found;

`ifdef CFG_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [IDX_W-1:0] ptr;
    assign search_base = ptr;
`endif

    // Index reached by stepping off places from base, wrapping NUM_REQ-1 -> 0.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        pick       = '0;
        pick_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!pick_found && req_valid[wrap_idx(search_base, off)]) begin
                pick_found = 1'b1;
                pick       = wrap_idx(search_base, off);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            cnt     <= '0;
            c_valid <= 1'b0;
            c_addr  <= '0;
            c_data  <= '0;
            req_ack <= '0;
            req_err <= '0;
            busy    <= 1'b0;
`ifndef CFG_ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every decision uses the pre-edge register values.
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant   <= pick;
                        c_addr  <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
                        c_data  <= req_data[int'(pick)*DATA_W +: DATA_W];
                        c_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                // The slave's ready still reflects the previous cycle here, so it is not sampled.
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (c_ready || (cnt == CNT_LAST)) begin
                        c_valid        <= 1'b0;
                        req_ack[grant] <= 1'b1;
                        req_err[grant] <= ~c_ready;
                        state          <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    req_ack <= '0;
                    req_err <= '0;
                    busy    <= 1'b0;
`ifndef CFG_ARB_FIXED_PRIO_EN
                    ptr     <= (grant == IDX_LAST) ? '0 : grant + 1'b1;
`endif
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed scoreboard bench for cfg_bus_arbiter: expected completions are queued at stimulus time
// and compared when req_ack pulses; a small slave model drives c_ready in several behaviours.
module tb_cfg_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_err;
    logic [ADDR_W-1:0]         c_addr;
    logic [DATA_W-1:0]         c_data;
    logic                      c_valid;
    logic                      c_ready;
    logic                      busy;

    typedef enum int {SL_NORMAL, SL_NEVER, SL_ALWAYS, SL_INV} slave_mode_t;
    slave_mode_t slave_mode = SL_NORMAL;

    typedef struct {
        int                g;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
        int                vcyc;
        int                lat;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    // Slave: ready is registered, so it answers one cycle after it sees c_valid.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_ready <= (slave_mode == SL_ALWAYS);
        end else begin
            case (slave_mode)
                SL_NORMAL: c_ready <= c_valid;
                SL_NEVER:  c_ready <= 1'b0;
                SL_ALWAYS: c_ready <= 1'b1;
                SL_INV:    c_ready <= ~c_valid;
                default:   c_ready <= 1'b0;
            endcase
        end
    end

    cfg_bus_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ack  (req_ack),
        .req_err  (req_err),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int g, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic err, input int vcyc, input int lat);
        exp_t e;
        e.g    = g;
        e.addr = a;
        e.data = d;
        e.err  = err;
        e.vcyc = vcyc;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic set_req(input int g, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[g*ADDR_W +: ADDR_W] = a;
        req_data[g*DATA_W +: DATA_W] = d;
        req_valid[g]                 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits (bounded) for the next completion; lat counts negedges from the call to the ack.
    task automatic wait_ack(input bit drop, input bit poke);
        int   vcnt;
        bit   seen;
        exp_t e;
        vcnt = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (c_valid && sb.size() != 0) begin
                check("c_addr_stable", c_addr, sb[0].addr);
                check("c_data_stable", c_data, sb[0].data);
                vcnt++;
            end
            if (req_ack != '0) begin
                seen = 1'b1;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("req_ack", req_ack, 1 << e.g);
                    check("req_err", req_err, e.err ? (1 << e.g) : 0);
                    check("valid_cycles", vcnt, e.vcyc);
                    check("ack_latency", i, e.lat);
                    check("c_valid_in_done", c_valid, 0);
                    check("busy_in_done", busy, 1);
                    if (drop) req_valid[e.g] = 1'b0;
                end
            end
            if (poke && i == 1 && sb.size() != 0) begin
                req_addr[sb[0].g*ADDR_W +: ADDR_W] = ~sb[0].addr;
                req_data[sb[0].g*DATA_W +: DATA_W] = ~sb[0].data;
            end
        end
        check("ack_seen", seen, 1);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        @(negedge clk);
        check("rst_req_ack", req_ack, 0);
        check("rst_req_err", req_err, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_c_addr", c_addr, 0);
        check("rst_c_data", c_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Single request, best-case latency.
        set_req(0, 2'b01, 8'h24);
        push_exp(0, 2'b01, 8'h24, 1'b0, 2, 3);
        wait_ack(1'b1, 1'b0);
        @(negedge clk);
        check("ack_one_cycle", req_ack, 0);
        check("err_one_cycle", req_err, 0);
        check("busy_after_done", busy, 0);

        // Two requesters held from reset: arbitration order and 4-cycle spacing.
        do_reset();
        set_req(0, 2'b01, 8'h11);
        set_req(1, 2'b10, 8'h22);
        for (int k = 0; k < 4; k++) begin
            int g;
`ifdef CFG_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = k % 2;
`endif
            push_exp(g, (g == 0) ? 2'b01 : 2'b10, (g == 0) ? 8'h11 : 8'h22, 1'b0, 2, (k == 0) ? 3 : 4);
        end
        for (int k = 0; k < 4; k++) wait_ack(1'b0, 1'b0);
        req_valid = '0;
        @(negedge clk);
        check("idle_after_pairs", busy, 0);

        // Slave never answers: 16 valid cycles, then error completion.
        slave_mode = SL_NEVER;
        set_req(0, 2'b01, 8'h5A);
        push_exp(0, 2'b01, 8'h5A, 1'b1, TIMEOUT + 1, TIMEOUT + 2);
        wait_ack(1'b1, 1'b0);
        @(negedge clk);
        check("timeout_ack_clear", req_ack, 0);
        check("timeout_err_clear", req_err, 0);

        // Latched address/data survive requester input changes mid-transaction.
        slave_mode = SL_NORMAL;
        set_req(1, 2'b10, 8'h40);
        push_exp(1, 2'b10, 8'h40, 1'b0, 2, 3);
        wait_ack(1'b1, 1'b1);
        @(negedge clk);

        // Move the pointer to 1, then abort a req1 transaction with reset.
        set_req(0, 2'b01, 8'h77);
        push_exp(0, 2'b01, 8'h77, 1'b0, 2, 3);
        wait_ack(1'b1, 1'b0);
        @(negedge clk);
        slave_mode = SL_NEVER;
        set_req(1, 2'b10, 8'h66);
        repeat (3) @(negedge clk);
        check("wait_c_valid", c_valid, 1);
        rst = 1'b0;
        #1;
        check("abort_c_valid", c_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", req_ack, 0);
        set_req(0, 2'b01, 8'h99);
        slave_mode = SL_NORMAL;
        @(negedge clk);
        rst = 1'b1;
        push_exp(0, 2'b01, 8'h99, 1'b0, 2, 3);
        wait_ack(1'b1, 1'b0);
        push_exp(1, 2'b10, 8'h66, 1'b0, 2, 4);
        wait_ack(1'b1, 1'b0);
        @(negedge clk);

        // Slave ready high from reset: must not complete from the ISSUE cycle.
        slave_mode = SL_ALWAYS;
        do_reset();
        set_req(0, 2'b01, 8'h33);
        push_exp(0, 2'b01, 8'h33, 1'b0, 2, 3);
        wait_ack(1'b1, 1'b0);
        @(negedge clk);

        // Ready only during ISSUE, low in WAIT: times out.
        slave_mode = SL_INV;
        set_req(1, 2'b10, 8'h5C);
        push_exp(1, 2'b10, 8'h5C, 1'b1, TIMEOUT + 1, TIMEOUT + 2);
        wait_ack(1'b1, 1'b0);
        @(negedge clk);
        check("final_ack_clear", req_ack, 0);
        check("final_busy", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests_run %0d", tests_run);
        $fatal(1);
    end

endmodule
